wb_regfile: RTL

//  - Integer register file; consumes the writeback bus from the MEM/WB pipeline register.
//  - Provides two synchronous read ports to ID/EX.
//  - After reset, a clear sequencer zeroes x1..x31, one register per cycle, BRAM-style.
//  - x0 is hardwired to zero; optional same-cycle WB->read bypass.

---
 rtl/wb_regfile.sv | 78 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - integer register file fed by the WB stage, two registered read ports, post-reset clear
// Optional feature macro: RF_BYPASS_EN (same-edge write-first read of the index being written).

module wb_regfile #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_WB,
  input  logic [ADDR_W-1:0] rd_WB,
  input  logic [DATA_W-1:0] rd_data_WB,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              init_busy
);

  localparam int unsigned      NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [0:NUM_REGS-1];

  // x0 reads as zero no matter what is stored or being written to it.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0) begin
      return '0;
    end
`ifdef RF_BYPASS_EN
    if (regwrite_WB && (rd_WB == addr)) begin
      return rd_data_WB;
    end
`endif
    return mem[addr];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_ptr   <= ADDR_W'(1);
      init_busy <= (CLEAR_ON_RESET != 0);
      rs1_data  <= '0;
      rs2_data  <= '0;
    end else if (state == CLEAR) begin
      if (clr_ptr == LAST_IDX) begin
        state     <= READY;
        init_busy <= 1'b0;
      end else begin
        clr_ptr <= clr_ptr + ADDR_W'(1);
      end
    end else if (rd_en) begin
      rs1_data <= read_port(rs1_addr);
      rs2_data <= read_port(rs2_addr);
    end
  end

  // Storage has no reset; the clear sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (regwrite_WB && (rd_WB != '0)) begin
        mem[rd_WB] <= rd_data_WB;
      end
    end
  end

endmodule
